// File: rtl/hmmm_host_loader_pkg.sv
// rtl/hmmm_host_loader_pkg.sv - shared widths, FSM states and error bit indices for the hmmm host loader
package hmmm_host_loader_pkg;
    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 8;
    localparam int ERR_TRUNC     = 0;
    localparam int ERR_UNDERFLOW = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE_RST = 3'd1,
        ST_LD_WAIT = 3'd2,
        ST_ADDR    = 3'd3,
        ST_DATA    = 3'd4,
        ST_BOOT    = 3'd5,
        ST_RUN     = 3'd6,
        ST_DONE    = 3'd7
    } state_t;
endpackage

// File: rtl/hmmm_host_loader_io_port.sv
// rtl/hmmm_host_loader_io_port.sv - RUN-phase servicing of core reads/writes on the shared bus
module hmmm_host_loader_io_port
    import hmmm_host_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_halt,
    input  logic [DATA_W-1:0] bus_i,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] bus_o,
    output logic              bus_oe,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              underflow
);
    logic              rd_act;
    logic              rd_first;
    logic              wr_act;
    logic              rd_q;
    logic [DATA_W-1:0] rd_hold;

    // Halt outranks both requests; a read outranks a simultaneous write.
    assign rd_act   = run && cpu_read && !cpu_halt;
    assign wr_act   = run && cpu_write && !cpu_read && !cpu_halt;
    assign rd_first = rd_act && !rd_q;
    assign in_ready = rd_first && in_valid;
    assign bus_oe   = rd_act;

    // A read held over several cycles pops once and keeps presenting that word.
    always_comb begin
        bus_o = '0;
        if (rd_first) begin
            bus_o = in_valid ? in_data : '0;
        end else if (rd_act) begin
            bus_o = rd_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= 1'b0;
            rd_hold   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_q      <= rd_act;
            out_valid <= wr_act;
            if (rd_first) begin
                rd_hold <= bus_o;
            end
            if (wr_act) begin
                out_data <= bus_i;
            end
            if (clr) begin
                underflow <= 1'b0;
            end else if (rd_first && !in_valid) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/hmmm_host_loader.sv
// rtl/hmmm_host_loader.sv - program loader, boot sequencer and I/O host for the hmmm core (option HMMM_LOADER_CHECKSUM_EN adds csum)
module hmmm_host_loader
    import hmmm_host_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              cpu_rst,
    output logic              pgrm_addr,
    output logic              pgrm_data,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_halt,
    input  logic [DATA_W-1:0] bus_i,
    output logic [DATA_W-1:0] bus_o,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
`ifdef HMMM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    logic              last;
    logic              err_trunc;
    logic              ld_oe;
    logic [DATA_W-1:0] ld_bus;
    logic              start_acc;
    logic              io_oe;
    logic [DATA_W-1:0] io_bus;
    logic              underflow;

    assign start_acc = start && (state == ST_IDLE || state == ST_DONE);
    assign busy      = !(state == ST_IDLE || state == ST_DONE);
    assign done      = (state == ST_DONE);
    assign bus_oe    = ld_oe | io_oe;
    assign bus_o     = ld_oe ? ld_bus : io_bus;

    always_comb begin
        err                = '0;
        err[ERR_TRUNC]     = err_trunc;
        err[ERR_UNDERFLOW] = underflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            word      <= '0;
            last      <= 1'b0;
            err_trunc <= 1'b0;
            cpu_rst   <= 1'b1;
            s_ready   <= 1'b0;
            pgrm_addr <= 1'b0;
            pgrm_data <= 1'b0;
            ld_oe     <= 1'b0;
            ld_bus    <= '0;
        end else begin
            pgrm_addr <= 1'b0;
            pgrm_data <= 1'b0;
            ld_oe     <= 1'b0;
            ld_bus    <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_acc) begin
                        addr      <= '0;
                        err_trunc <= 1'b0;
                        cpu_rst   <= 1'b1;
                        state     <= ST_PRE_RST;
                    end
                end
                ST_PRE_RST: begin
                    cpu_rst <= 1'b0;
                    s_ready <= 1'b1;
                    state   <= ST_LD_WAIT;
                end
                ST_LD_WAIT: begin
                    if (s_valid) begin
                        word      <= s_data;
                        last      <= s_last;
                        s_ready   <= 1'b0;
                        pgrm_addr <= 1'b1;
                        ld_oe     <= 1'b1;
                        ld_bus    <= DATA_W'(addr);
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    pgrm_data <= 1'b1;
                    ld_oe     <= 1'b1;
                    ld_bus    <= word;
                    state     <= ST_DATA;
                end
                ST_DATA: begin
                    addr <= addr + 1'b1;
                    // Filling the last address ends the load even without s_last.
                    if (last || addr == {ADDR_W{1'b1}}) begin
                        err_trunc <= !last;
                        cpu_rst   <= 1'b1;
                        state     <= ST_BOOT;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= ST_LD_WAIT;
                    end
                end
                ST_BOOT: begin
                    cpu_rst <= 1'b0;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (cpu_halt) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HMMM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            csum <= '0;
        end else if (state == ST_DATA) begin
            csum <= csum + word;
        end
    end
`endif

    hmmm_host_loader_io_port #(
        .DATA_W(DATA_W)
    ) u_io_port (
        .clk      (clk),
        .rst      (rst),
        .run      (state == ST_RUN),
        .clr      (start_acc),
        .cpu_read (cpu_read),
        .cpu_write(cpu_write),
        .cpu_halt (cpu_halt),
        .bus_i    (bus_i),
        .in_data  (in_data),
        .in_valid (in_valid),
        .bus_o    (io_bus),
        .bus_oe   (io_oe),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .underflow(underflow)
    );
endmodule
